// File: rtl/pixel_pkg.sv
// Shared types for the pixel packer and its output buffer.
//   state_e     : packer FSM states
//   rgb565_t    : one RGB565 pixel
//   buf_entry_t : one output-buffer entry {word, sof, eof}
package pixel_pkg;

  localparam int unsigned PIX_PER_WORD = 4;

  typedef enum logic [1:0] {
    S_SYNC,
    S_PACK,
    S_FLUSH
  } state_e;

  typedef logic [15:0] rgb565_t;

  typedef struct packed {
    logic [63:0] word;
    logic        sof;
    logic        eof;
  } buf_entry_t;

endpackage

// File: rtl/pixel_skid_buf.sv
// Two-entry valid/ready FIFO for buf_entry_t words.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   i_push       : write i_entry this cycle
//   i_entry      : entry to write
//   o_valid      : buffer not empty; o_head is the oldest entry
//   i_ready      : consumer takes o_head when o_valid && i_ready
//   o_head       : oldest entry
//   o_full       : both entries occupied
//   o_drop       : pulse, a push was discarded because the buffer was full
module pixel_skid_buf
  import pixel_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  buf_entry_t i_entry,
  output logic       o_valid,
  input  logic       i_ready,
  output buf_entry_t o_head,
  output logic       o_full,
  output logic       o_drop
);

  buf_entry_t r_mem [2];
  logic       r_rd;
  logic       r_wr;
  logic [1:0] r_cnt;

  logic w_pop;
  logic w_push_ok;

  assign o_valid   = (r_cnt != 2'd0);
  assign o_full    = (r_cnt == 2'd2);
  assign o_head    = r_mem[r_rd];
  assign w_pop     = o_valid && i_ready;
  // A pop in the same cycle frees a slot, so a push into a full buffer still lands.
  assign w_push_ok = i_push && (!o_full || w_pop);
  assign o_drop    = i_push && o_full && !w_pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr] <= i_entry;
        r_wr        <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/pixel_packer.sv
// Packs four RGB565 pixels into one 64-bit word (pixel0 in [15:0]) tagged with
// start/end-of-frame markers, and presents it through a two-entry buffer.
// Ports:
//   clk, rst_n          : pixel clock, synchronous active-low reset
//   i_pixel_data/valid  : pixel stream from the mixer
//   i_frame_done        : one-cycle end-of-frame strobe
//   o_word/o_word_valid : packed word out, taken when i_word_ready is high
//   o_sof/o_eof         : first/last word of frame, qualify o_word
//   o_overflow          : sticky, a completed word or flush pixel was dropped
//   o_frame_err         : sticky, frame ended at the wrong word count
// Optional build macro PIXEL_PACKER_STATS_EN adds:
//   o_frame_cnt         : eof words consumed, wrapping
//   o_drop_cnt          : words dropped by the buffer, saturating
module pixel_packer
  import pixel_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_pixel_data,
  input  logic        i_pixel_valid,
  input  logic        i_frame_done,
  output logic [63:0] o_word,
  output logic        o_word_valid,
  input  logic        i_word_ready,
  output logic        o_sof,
  output logic        o_eof,
  output logic        o_overflow,
  output logic        o_frame_err
`ifdef PIXEL_PACKER_STATS_EN
  ,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_drop_cnt
`endif
);

  localparam int unsigned WORDS_PER_FRAME = H_ACTIVE * V_ACTIVE / PIX_PER_WORD;
  localparam int unsigned WCNT_W          = $clog2(WORDS_PER_FRAME + 1);
  localparam logic [WCNT_W-1:0] LastWord  = WCNT_W'(WORDS_PER_FRAME - 1);

  state_e            r_state;
  logic [1:0]        r_lane;
  logic [WCNT_W-1:0] r_wcnt;
  rgb565_t           r_pix [PIX_PER_WORD];
  // Set once the frame's last word is packed; pixels after it are excess.
  logic              r_frame_full;
  // Staging register: the completed word enters the buffer one edge later.
  buf_entry_t        r_stg;
  logic              r_stg_vld;
  logic              r_overflow;
  logic              r_frame_err;

  logic              w_pix_take;
  logic              w_word_done;
  logic [1:0]        w_lane_post;
  logic [WCNT_W-1:0] w_wcnt_post;
  logic              w_full_post;
  logic [63:0]       w_flush_word;
  logic              w_pop;
  logic              w_buf_full;
  logic              w_buf_room;
  logic              w_drop;
  buf_entry_t        w_head;

  assign w_pix_take  = (r_state == S_PACK) && i_pixel_valid && !r_frame_full;
  assign w_word_done = w_pix_take && (r_lane == 2'd3);
  assign w_lane_post = w_pix_take ? r_lane + 2'd1 : r_lane;
  assign w_full_post = r_frame_full || (w_word_done && (r_wcnt == LastWord));
  assign w_pop       = o_word_valid && i_word_ready;
  assign w_buf_room  = !w_buf_full || w_pop;

  always_comb begin
    w_wcnt_post = r_wcnt;
    if (w_word_done) begin
      w_wcnt_post = (r_wcnt == LastWord) ? '0 : r_wcnt + 1'b1;
    end
  end

  // Lanes at or above the current lane are unfilled and padded with zero.
  always_comb begin
    w_flush_word = '0;
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < r_lane) begin
        w_flush_word[16*i +: 16] = r_pix[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_SYNC;
      r_lane       <= 2'd0;
      r_wcnt       <= '0;
      for (int i = 0; i < PIX_PER_WORD; i++) r_pix[i] <= '0;
      r_frame_full <= 1'b0;
      r_stg        <= '0;
      r_stg_vld    <= 1'b0;
      r_overflow   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_stg_vld <= 1'b0;
      if (w_drop) r_overflow <= 1'b1;
      case (r_state)
        S_SYNC: begin
          if (i_frame_done) r_state <= S_PACK;
        end
        S_PACK: begin
          if (i_pixel_valid && r_frame_full) r_frame_err <= 1'b1;
          if (w_pix_take) r_pix[r_lane] <= i_pixel_data;
          if (w_word_done) begin
            r_stg.word <= {i_pixel_data, r_pix[2], r_pix[1], r_pix[0]};
            r_stg.sof  <= (r_wcnt == '0);
            r_stg.eof  <= (r_wcnt == LastWord);
            r_stg_vld  <= 1'b1;
          end
          r_lane       <= w_lane_post;
          r_wcnt       <= w_wcnt_post;
          r_frame_full <= w_full_post;
          // frame_done sees the lane/count after this cycle's pixel.
          if (i_frame_done) begin
            r_frame_full <= 1'b0;
            if (w_lane_post != 2'd0) begin
              r_state <= S_FLUSH;
            end else if (w_wcnt_post != '0) begin
              r_frame_err <= 1'b1;
              r_wcnt      <= '0;
            end
          end
        end
        S_FLUSH: begin
          if (i_pixel_valid) r_overflow <= 1'b1;
          // Stage only when the buffer is sure to accept the word next edge.
          if (!r_stg_vld && w_buf_room) begin
            r_stg.word  <= w_flush_word;
            r_stg.sof   <= (r_wcnt == '0);
            r_stg.eof   <= 1'b1;
            r_stg_vld   <= 1'b1;
            r_frame_err <= 1'b1;
            r_lane      <= 2'd0;
            r_wcnt      <= '0;
            r_state     <= S_PACK;
          end
        end
        default: r_state <= S_SYNC;
      endcase
    end
  end

  pixel_skid_buf u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_stg_vld),
    .i_entry (r_stg),
    .o_valid (o_word_valid),
    .i_ready (i_word_ready),
    .o_head  (w_head),
    .o_full  (w_buf_full),
    .o_drop  (w_drop)
  );

  assign o_word      = w_head.word;
  assign o_sof       = w_head.sof;
  assign o_eof       = w_head.eof;
  assign o_overflow  = r_overflow;
  assign o_frame_err = r_frame_err;

`ifdef PIXEL_PACKER_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_pop && w_head.eof) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
  assign o_drop_cnt  = r_drop_cnt;
`endif

endmodule

// File: tb/tb_pixel_packer.sv
// Directed bench for pixel_packer with an 8x2 frame (four words per frame).
module tb_pixel_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_pixel_data;
  logic        i_pixel_valid;
  logic        i_frame_done;
  logic [63:0] o_word;
  logic        o_word_valid;
  logic        i_word_ready;
  logic        o_sof;
  logic        o_eof;
  logic        o_overflow;
  logic        o_frame_err;
`ifdef PIXEL_PACKER_STATS_EN
  logic [15:0] o_frame_cnt;
  logic [15:0] o_drop_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Consumed words as {word, sof, eof}.
  logic [65:0] q [$];

  always #5 clk = ~clk;

  pixel_packer #(
    .H_ACTIVE (8),
    .V_ACTIVE (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_pixel_data  (i_pixel_data),
    .i_pixel_valid (i_pixel_valid),
    .i_frame_done  (i_frame_done),
    .o_word        (o_word),
    .o_word_valid  (o_word_valid),
    .i_word_ready  (i_word_ready),
    .o_sof         (o_sof),
    .o_eof         (o_eof),
    .o_overflow    (o_overflow),
    .o_frame_err   (o_frame_err)
`ifdef PIXEL_PACKER_STATS_EN
    ,
    .o_frame_cnt   (o_frame_cnt),
    .o_drop_cnt    (o_drop_cnt)
`endif
  );

  // Inputs change just after posedge, so negedge sees what the next edge will use.
  always @(negedge clk) begin
    if (rst_n && o_word_valid && i_word_ready) q.push_back({o_word, o_sof, o_eof});
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send_pixel(input logic [15:0] d);
    i_pixel_data  = d;
    i_pixel_valid = 1'b1;
    cycle();
    i_pixel_valid = 1'b0;
  endtask

  task automatic frame_done();
    i_frame_done = 1'b1;
    cycle();
    i_frame_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (o_word !== 64'd0) begin n_err++;
      $display("FAIL reset_word got %h want 0", o_word); end
    n_cmp++; if (o_word_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_valid got %b want 0", o_word_valid); end
    n_cmp++; if ({o_sof, o_eof, o_overflow, o_frame_err} !== 4'b0) begin n_err++;
      $display("FAIL reset_flags got %b want 0000", {o_sof, o_eof, o_overflow, o_frame_err}); end
  endtask

  task automatic test_normal_frame();
    for (int i = 0; i < 4; i++) send_pixel(16'h0011 + 16'(i));
    idle(3);
    n_cmp++; if (q.size() !== 0) begin n_err++;
      $display("FAIL presync_words got %0d want 0", q.size()); end
    frame_done();
    for (int i = 1; i <= 4; i++) send_pixel(16'(i));
    n_cmp++; if (o_word_valid !== 1'b0) begin n_err++;
      $display("FAIL latency_edgeN got %b want 0", o_word_valid); end
    send_pixel(16'd5);
    n_cmp++; if (o_word_valid !== 1'b1) begin n_err++;
      $display("FAIL latency_edgeN1 got %b want 1", o_word_valid); end
    for (int i = 6; i <= 16; i++) send_pixel(16'(i));
    frame_done();
    idle(4);
    n_cmp++; if (q.size() !== 4) begin n_err++;
      $display("FAIL normal_count got %0d want 4", q.size()); end
    n_cmp++; if (q[0] !== {64'h0004_0003_0002_0001, 2'b10}) begin n_err++;
      $display("FAIL normal_word0 got %h want %h", q[0], {64'h0004_0003_0002_0001, 2'b10}); end
    n_cmp++; if (q[1] !== {64'h0008_0007_0006_0005, 2'b00}) begin n_err++;
      $display("FAIL normal_word1 got %h want %h", q[1], {64'h0008_0007_0006_0005, 2'b00}); end
    n_cmp++; if (q[3] !== {64'h0010_000F_000E_000D, 2'b01}) begin n_err++;
      $display("FAIL normal_word3 got %h want %h", q[3], {64'h0010_000F_000E_000D, 2'b01}); end
    n_cmp++; if ({o_overflow, o_frame_err} !== 2'b00) begin n_err++;
      $display("FAIL normal_flags got %b want 00", {o_overflow, o_frame_err}); end
  endtask

  task automatic test_short_frame();
    q.delete();
    for (int i = 1; i <= 6; i++) send_pixel(16'h00A0 + 16'(i));
    frame_done();
    idle(4);
    n_cmp++; if (q.size() !== 2) begin n_err++;
      $display("FAIL short_count got %0d want 2", q.size()); end
    n_cmp++; if (q[0] !== {64'h00A4_00A3_00A2_00A1, 2'b10}) begin n_err++;
      $display("FAIL short_word0 got %h want %h", q[0], {64'h00A4_00A3_00A2_00A1, 2'b10}); end
    n_cmp++; if (q[1] !== {64'h0000_0000_00A6_00A5, 2'b01}) begin n_err++;
      $display("FAIL short_flush got %h want %h", q[1], {64'h0000_0000_00A6_00A5, 2'b01}); end
    n_cmp++; if (o_frame_err !== 1'b1) begin n_err++;
      $display("FAIL short_frame_err got %b want 1", o_frame_err); end
    for (int i = 1; i <= 4; i++) send_pixel(16'h00B0 + 16'(i));
    idle(3);
    n_cmp++; if (q[2] !== {64'h00B4_00B3_00B2_00B1, 2'b10}) begin n_err++;
      $display("FAIL short_next_sof got %h want %h", q[2], {64'h00B4_00B3_00B2_00B1, 2'b10}); end
    n_cmp++; if (o_overflow !== 1'b0) begin n_err++;
      $display("FAIL short_overflow got %b want 0", o_overflow); end
  endtask

  task automatic test_overflow();
    do_reset();
    frame_done();
    i_word_ready = 1'b0;
    for (int i = 1; i <= 12; i++) send_pixel(16'h0100 + 16'(i));
    idle(3);
    n_cmp++; if (o_overflow !== 1'b1) begin n_err++;
      $display("FAIL ovf_flag got %b want 1", o_overflow); end
    n_cmp++; if ({o_word_valid, o_word, o_sof} !== {1'b1, 64'h0104_0103_0102_0101, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_head got %h want %h", {o_word_valid, o_word, o_sof},
               {1'b1, 64'h0104_0103_0102_0101, 1'b1}); end
`ifdef PIXEL_PACKER_STATS_EN
    n_cmp++; if (o_drop_cnt !== 16'd1) begin n_err++;
      $display("FAIL ovf_drop_cnt got %0d want 1", o_drop_cnt); end
`endif
    i_word_ready = 1'b1;
    idle(4);
    n_cmp++; if (q.size() !== 2) begin n_err++;
      $display("FAIL ovf_drain_count got %0d want 2", q.size()); end
    n_cmp++; if (q[0] !== {64'h0104_0103_0102_0101, 2'b10}) begin n_err++;
      $display("FAIL ovf_drain0 got %h want %h", q[0], {64'h0104_0103_0102_0101, 2'b10}); end
    n_cmp++; if (q[1] !== {64'h0108_0107_0106_0105, 2'b00}) begin n_err++;
      $display("FAIL ovf_drain1 got %h want %h", q[1], {64'h0108_0107_0106_0105, 2'b00}); end
    // The dropped word still counted, so the next word closes the frame.
    for (int i = 13; i <= 16; i++) send_pixel(16'h0100 + 16'(i));
    frame_done();
    idle(4);
    n_cmp++; if (q[2] !== {64'h0110_010F_010E_010D, 2'b01}) begin n_err++;
      $display("FAIL ovf_eof got %h want %h", q[2], {64'h0110_010F_010E_010D, 2'b01}); end
    n_cmp++; if (o_frame_err !== 1'b0) begin n_err++;
      $display("FAIL ovf_frame_err got %b want 0", o_frame_err); end
`ifdef PIXEL_PACKER_STATS_EN
    n_cmp++; if (o_frame_cnt !== 16'd1) begin n_err++;
      $display("FAIL ovf_frame_cnt got %0d want 1", o_frame_cnt); end
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    frame_done();
    for (int i = 1; i <= 15; i++) send_pixel(16'h0200 + 16'(i));
    i_frame_done = 1'b1;
    send_pixel(16'h0210);
    i_frame_done = 1'b0;
    idle(4);
    n_cmp++; if (q.size() !== 4) begin n_err++;
      $display("FAIL b2b_count got %0d want 4", q.size()); end
    n_cmp++; if (q[3] !== {64'h0210_020F_020E_020D, 2'b01}) begin n_err++;
      $display("FAIL b2b_eof got %h want %h", q[3], {64'h0210_020F_020E_020D, 2'b01}); end
    n_cmp++; if (o_frame_err !== 1'b0) begin n_err++;
      $display("FAIL b2b_frame_err got %b want 0", o_frame_err); end
  endtask

  task automatic test_mid_reset();
    q.delete();
    for (int i = 1; i <= 6; i++) send_pixel(16'h0300 + 16'(i));
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    n_cmp++; if ({o_word_valid, o_word, o_sof, o_eof, o_overflow, o_frame_err} !== 69'd0) begin
      n_err++;
      $display("FAIL midrst_outputs got %h want 0",
               {o_word_valid, o_word, o_sof, o_eof, o_overflow, o_frame_err}); end
    q.delete();
    for (int i = 1; i <= 4; i++) send_pixel(16'h0400 + 16'(i));
    idle(3);
    n_cmp++; if (q.size() !== 0) begin n_err++;
      $display("FAIL midrst_nosync got %0d want 0", q.size()); end
    frame_done();
    for (int i = 1; i <= 4; i++) send_pixel(16'h0500 + 16'(i));
    idle(3);
    n_cmp++; if (q[0] !== {64'h0504_0503_0502_0501, 2'b10}) begin n_err++;
      $display("FAIL midrst_resync got %h want %h", q[0], {64'h0504_0503_0502_0501, 2'b10}); end
  endtask

  initial begin
    rst_n         = 1'b0;
    i_pixel_data  = '0;
    i_pixel_valid = 1'b0;
    i_frame_done  = 1'b0;
    i_word_ready  = 1'b1;
    test_reset();
    test_normal_frame();
    test_short_frame();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
